instr_encoder: RTL and testbench

Streaming RV32I instruction encoder, the inverse of the core's control-unit decode. It accepts symbolic operation requests (operation kind, register indices, immediate) over a valid/ready handshake and emits 32-bit machine words with their target word addresses over a second valid/ready stream. The output stream feeds the instruction-memory loader used by the boot/self-test path. It covers exactly the operation set the core decodes. The pseudo-instruction LI expands to one or two words.

---
 rtl/instr_encoder_pkg.sv | 70 +++++++
 rtl/instr_encoder_if.sv | 23 ++
 rtl/instr_encoder_field_pack.sv | 75 +++++++
 rtl/instr_encoder.sv | 82 ++++++++
 tb/tb_instr_encoder.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the RV32I instruction encoder: operation kinds, opcode and
// funct fields, FSM state encoding and small field-packing helpers.
package instr_enc_pkg;

   typedef enum logic [4:0] {
      OP_ADD   = 5'd0,  OP_SUB   = 5'd1,  OP_AND   = 5'd2,  OP_OR    = 5'd3,
      OP_XOR   = 5'd4,  OP_SLT   = 5'd5,  OP_ADDI  = 5'd6,  OP_ORI   = 5'd7,
      OP_ANDI  = 5'd8,  OP_SLTI  = 5'd9,  OP_LB    = 5'd10, OP_LH    = 5'd11,
      OP_LW    = 5'd12, OP_LBU   = 5'd13, OP_LHU   = 5'd14, OP_SB    = 5'd15,
      OP_SH    = 5'd16, OP_SW    = 5'd17, OP_BEQ   = 5'd18, OP_BNE   = 5'd19,
      OP_JAL   = 5'd20, OP_JALR  = 5'd21, OP_LUI   = 5'd22, OP_AUIPC = 5'd23,
      OP_NOP   = 5'd24, OP_LI    = 5'd25
   } op_e;

   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_I      = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [2:0] F3_ADD = 3'b000, F3_SLT = 3'b010, F3_XOR = 3'b100;
   localparam logic [2:0] F3_OR  = 3'b110, F3_AND = 3'b111;
   localparam logic [2:0] F3_B   = 3'b000, F3_H   = 3'b001, F3_W   = 3'b010;
   localparam logic [2:0] F3_BU  = 3'b100, F3_HU  = 3'b101;
   localparam logic [2:0] F3_BEQ = 3'b000, F3_BNE = 3'b001;
   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_SUB  = 7'b0100000;

   // FSM state encoding
   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_HOLD  = 2'd1;
   localparam logic [1:0] ST_HOLD2 = 2'd2;

   function automatic logic fits_s(input logic [31:0] v, input int n);
      logic [31:0] t;
      t = $unsigned($signed(v) >>> (n - 1));
      return (t == '0) || (t == '1);
   endfunction

   function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, OPC_R};
   endfunction

   function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] opc);
      return {imm, rs1, f3, rd, opc};
   endfunction

   function automatic logic [31:0] s_type(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
   endfunction

   function automatic logic [31:0] b_type(input logic [12:1] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
   endfunction

   function automatic logic [31:0] j_type(input logic [20:1] imm, input logic [4:0] rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
   endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request and output-word streams of the instruction encoder.
interface instr_encoder_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   logic                  req_valid;
   logic                  req_ready;
   logic [4:0]            req_op;
   logic [4:0]            req_rd;
   logic [4:0]            req_rs1;
   logic [4:0]            req_rs2;
   logic [DATA_WIDTH-1:0] req_imm;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_instr;
   logic [ADDR_WIDTH-1:0] out_addr;
   logic                  err;

   modport master (output req_valid, req_op, req_rd, req_rs1, req_rs2, req_imm, out_ready,
                   input  req_ready, out_valid, out_instr, out_addr, err);
   modport slave  (input  req_valid, req_op, req_rd, req_rs1, req_rs2, req_imm, out_ready,
                   output req_ready, out_valid, out_instr, out_addr, err);
endinterface

// File: rtl/instr_encoder_field_pack.sv
// Combinational packing of one symbolic request into an RV32I word, with range check
// and the optional second (ADDI) word of an LI expansion.
module instr_field_pack
   import instr_enc_pkg::*;
(
   input  logic [4:0]  op,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [31:0] imm,
   output logic [31:0] word,
   output logic [31:0] word2,
   output logic        range_ok,
   output logic        two_word
);
   logic        fit12;
   logic [19:0] li_hi;

   assign fit12 = fits_s(imm, 12);
   // Rounding the upper part compensates for the sign-extended low 12 bits of the ADDI.
   assign li_hi = imm[31:12] + {19'b0, imm[11]};

   always_comb begin
      word     = '0;
      word2    = '0;
      range_ok = 1'b1;
      two_word = 1'b0;
      case (op)
         OP_ADD:   word = r_type(F7_BASE, rs2, rs1, F3_ADD, rd);
         OP_SUB:   word = r_type(F7_SUB,  rs2, rs1, F3_ADD, rd);
         OP_AND:   word = r_type(F7_BASE, rs2, rs1, F3_AND, rd);
         OP_OR:    word = r_type(F7_BASE, rs2, rs1, F3_OR,  rd);
         OP_XOR:   word = r_type(F7_BASE, rs2, rs1, F3_XOR, rd);
         OP_SLT:   word = r_type(F7_BASE, rs2, rs1, F3_SLT, rd);
         OP_ADDI:  begin word = i_type(imm[11:0], rs1, F3_ADD, rd, OPC_I);    range_ok = fit12; end
         OP_ORI:   begin word = i_type(imm[11:0], rs1, F3_OR,  rd, OPC_I);    range_ok = fit12; end
         OP_ANDI:  begin word = i_type(imm[11:0], rs1, F3_AND, rd, OPC_I);    range_ok = fit12; end
         OP_SLTI:  begin word = i_type(imm[11:0], rs1, F3_SLT, rd, OPC_I);    range_ok = fit12; end
         OP_LB:    begin word = i_type(imm[11:0], rs1, F3_B,   rd, OPC_LOAD); range_ok = fit12; end
         OP_LH:    begin word = i_type(imm[11:0], rs1, F3_H,   rd, OPC_LOAD); range_ok = fit12; end
         OP_LW:    begin word = i_type(imm[11:0], rs1, F3_W,   rd, OPC_LOAD); range_ok = fit12; end
         OP_LBU:   begin word = i_type(imm[11:0], rs1, F3_BU,  rd, OPC_LOAD); range_ok = fit12; end
         OP_LHU:   begin word = i_type(imm[11:0], rs1, F3_HU,  rd, OPC_LOAD); range_ok = fit12; end
         OP_JALR:  begin word = i_type(imm[11:0], rs1, F3_ADD, rd, OPC_JALR); range_ok = fit12; end
         OP_SB:    begin word = s_type(imm[11:0], rs2, rs1, F3_B); range_ok = fit12; end
         OP_SH:    begin word = s_type(imm[11:0], rs2, rs1, F3_H); range_ok = fit12; end
         OP_SW:    begin word = s_type(imm[11:0], rs2, rs1, F3_W); range_ok = fit12; end
         OP_BEQ:   begin
            word     = b_type(imm[12:1], rs2, rs1, F3_BEQ);
            range_ok = !imm[0] && fits_s(imm, 13);
         end
         OP_BNE:   begin
            word     = b_type(imm[12:1], rs2, rs1, F3_BNE);
            range_ok = !imm[0] && fits_s(imm, 13);
         end
         OP_JAL:   begin
            word     = j_type(imm[20:1], rd);
            range_ok = !imm[0] && fits_s(imm, 21);
         end
         OP_LUI:   begin word = {imm[19:0], rd, OPC_LUI};   range_ok = (imm[31:20] == '0); end
         OP_AUIPC: begin word = {imm[19:0], rd, OPC_AUIPC}; range_ok = (imm[31:20] == '0); end
         OP_NOP:   word = i_type(12'h000, 5'd0, F3_ADD, 5'd0, OPC_I);
         OP_LI:    begin
            if (fit12) begin
               word = i_type(imm[11:0], 5'd0, F3_ADD, rd, OPC_I);
            end else begin
               word     = {li_hi, rd, OPC_LUI};
               word2    = i_type(imm[11:0], rd, F3_ADD, rd, OPC_I);
               two_word = (imm[11:0] != '0);
            end
         end
         default:  range_ok = 1'b0;
      endcase
   end
endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32I encoder: request handshake in, addressed machine words out,
// with LI expanded into one or two words.
//
//   state | meaning
//   EMPTY | no word held, ready for a request
//   HOLD  | one word presented; refills in the same cycle it is taken
//   HOLD2 | LUI presented, its ADDI waiting in pend_instr
module instr_encoder
   import instr_enc_pkg::*;
#(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
   input logic            clk,
   input logic            rst_n,
   instr_encoder_if.slave bus
);
   logic [1:0]            state;
   logic [DATA_WIDTH-1:0] out_instr;
   logic [DATA_WIDTH-1:0] pend_instr;
   logic [ADDR_WIDTH-1:0] out_addr;
   logic                  err;
   logic [31:0]           word, word2;
   logic                  range_ok, two_word;
   logic                  req_ready, accept, legal, fire, out_valid;

   instr_field_pack u_pack (
      .op       (bus.req_op),
      .rd       (bus.req_rd),
      .rs1      (bus.req_rs1),
      .rs2      (bus.req_rs2),
      .imm      (bus.req_imm),
      .word     (word),
      .word2    (word2),
      .range_ok (range_ok),
      .two_word (two_word)
   );

   assign out_valid = (state != ST_EMPTY);
   assign req_ready = (state == ST_EMPTY) || ((state == ST_HOLD) && bus.out_ready);
   assign accept    = bus.req_valid && req_ready;
   assign legal     = range_ok;
   assign fire      = out_valid && bus.out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_EMPTY;
         out_instr  <= '0;
         pend_instr <= '0;
         out_addr   <= BASE_ADDR;
         err        <= 1'b0;
      end else begin
         err <= accept && !legal;
         if (fire) out_addr <= out_addr + ADDR_WIDTH'(4);
         case (state)
            ST_EMPTY, ST_HOLD: begin
               if (accept && legal) begin
                  out_instr  <= word;
                  pend_instr <= word2;
                  state      <= two_word ? ST_HOLD2 : ST_HOLD;
               end else if (fire) begin
                  state <= ST_EMPTY;
               end
            end
            ST_HOLD2: begin
               if (fire) begin
                  out_instr <= pend_instr;
                  state     <= ST_HOLD;
               end
            end
            default: state <= ST_EMPTY;
         endcase
      end
   end

   assign bus.req_ready = req_ready;
   assign bus.out_valid = out_valid;
   assign bus.out_instr = out_instr;
   assign bus.out_addr  = out_addr;
   assign bus.err       = err;
endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder with hand-computed RV32I words.
module tb_instr_encoder;
   import instr_enc_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   failures = 0;

   instr_encoder_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

   instr_encoder #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .BASE_ADDR(32'h0)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic req(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm);
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_rd    = rd;
      bus.req_rs1   = rs1;
      bus.req_rs2   = rs2;
      bus.req_imm   = imm;
   endtask

   initial begin
      rst_n = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_op    = '0;
      bus.req_rd    = '0;
      bus.req_rs1   = '0;
      bus.req_rs2   = '0;
      bus.req_imm   = '0;
      bus.out_ready = 1'b0;
      tick();
      sample();
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_instr", bus.out_instr, 32'h0);
      chk("rst_out_addr",  bus.out_addr,  32'h0);
      chk("rst_err",       32'(bus.err),  32'd0);
      chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
      tick();
      rst_n = 1'b1;
      tick();

      // ADD then NOP back-to-back
      bus.out_ready = 1'b1;
      req(OP_ADD, 5'd1, 5'd2, 5'd3, 32'h0);
      tick();
      req(OP_NOP, 5'd0, 5'd0, 5'd0, 32'h0);
      sample();
      chk("add_valid", 32'(bus.out_valid), 32'd1);
      chk("add_instr", bus.out_instr, 32'h003100B3);
      chk("add_addr",  bus.out_addr,  32'h0);
      chk("add_rdy",   32'(bus.req_ready), 32'd1);
      tick();
      bus.req_valid = 1'b0;
      sample();
      chk("nop_instr", bus.out_instr, 32'h00000013);
      chk("nop_addr",  bus.out_addr,  32'h4);
      tick();
      sample();
      chk("idle_valid", 32'(bus.out_valid), 32'd0);
      chk("idle_addr",  bus.out_addr, 32'h8);

      // LI 0x12345678, first word held under backpressure
      bus.out_ready = 1'b0;
      req(OP_LI, 5'd5, 5'd0, 5'd0, 32'h12345678);
      tick();
      bus.req_valid = 1'b0;
      sample();
      chk("li1_lui",   bus.out_instr, 32'h123452B7);
      chk("li1_addr0", bus.out_addr,  32'h8);
      chk("li1_rdy",   32'(bus.req_ready), 32'd0);
      bus.out_ready = 1'b1;
      tick();
      sample();
      chk("li1_addi",  bus.out_instr, 32'h67828293);
      chk("li1_addr1", bus.out_addr,  32'hC);
      chk("li1_valid", 32'(bus.out_valid), 32'd1);
      tick();

      // LI 0xFFF: two words with rounded upper part
      req(OP_LI, 5'd5, 5'd0, 5'd0, 32'h00000FFF);
      tick();
      bus.req_valid = 1'b0;
      sample();
      chk("li2_lui",  bus.out_instr, 32'h000012B7);
      chk("li2_addr", bus.out_addr,  32'h10);
      tick();
      sample();
      chk("li2_addi", bus.out_instr, 32'hFFF28293);
      chk("li2_addr1", bus.out_addr, 32'h14);
      tick();

      // LI 0x7FF: single word
      req(OP_LI, 5'd5, 5'd0, 5'd0, 32'h000007FF);
      tick();
      bus.req_valid = 1'b0;
      sample();
      chk("li3_addi", bus.out_instr, 32'h7FF00293);
      chk("li3_addr", bus.out_addr,  32'h18);
      tick();
      sample();
      chk("li3_single", 32'(bus.out_valid), 32'd0);

      // BEQ -8, SW -4
      req(OP_BEQ, 5'd0, 5'd1, 5'd2, -32'sd8);
      tick();
      req(OP_SW, 5'd0, 5'd2, 5'd5, -32'sd4);
      sample();
      chk("beq_instr", bus.out_instr, 32'hFE208CE3);
      chk("beq_addr",  bus.out_addr,  32'h1C);
      chk("beq_err",   32'(bus.err),  32'd0);
      tick();
      bus.req_valid = 1'b0;
      sample();
      chk("sw_instr", bus.out_instr, 32'hFE512E23);
      chk("sw_addr",  bus.out_addr,  32'h20);
      tick();

      // odd branch offset -> err pulse, nothing emitted
      req(OP_BEQ, 5'd0, 5'd1, 5'd2, 32'd3);
      tick();
      bus.req_valid = 1'b0;
      sample();
      chk("beq3_err",   32'(bus.err), 32'd1);
      chk("beq3_valid", 32'(bus.out_valid), 32'd0);
      chk("beq3_addr",  bus.out_addr, 32'h24);
      tick();
      sample();
      chk("beq3_err_clr", 32'(bus.err), 32'd0);
      chk("beq3_addr2",   bus.out_addr, 32'h24);

      // ADDI 2048 out of range, then illegal op code
      req(OP_ADDI, 5'd1, 5'd1, 5'd0, 32'd2048);
      tick();
      req(5'd31, 5'd1, 5'd1, 5'd1, 32'd0);
      sample();
      chk("addi_rng_err", 32'(bus.err), 32'd1);
      tick();
      bus.req_valid = 1'b0;
      sample();
      chk("illop_err",   32'(bus.err), 32'd1);
      chk("illop_valid", 32'(bus.out_valid), 32'd0);
      tick();
      // LUI with nonzero imm[31:20]
      req(OP_LUI, 5'd1, 5'd0, 5'd0, 32'h00100000);
      tick();
      bus.req_valid = 1'b0;
      sample();
      chk("lui_rng_err", 32'(bus.err), 32'd1);
      tick();

      // backpressure: JAL held 3 cycles while SUB waits
      bus.out_ready = 1'b0;
      req(OP_JAL, 5'd1, 5'd0, 5'd0, 32'd8);
      tick();
      req(OP_SUB, 5'd3, 5'd1, 5'd2, 32'd0);
      for (int i = 0; i < 3; i++) begin
         sample();
         chk("bp_instr", bus.out_instr, 32'h008000EF);
         chk("bp_addr",  bus.out_addr,  32'h24);
         chk("bp_rdy",   32'(bus.req_ready), 32'd0);
         tick();
      end
      bus.out_ready = 1'b1;
      tick();
      bus.req_valid = 1'b0;
      sample();
      chk("bp_sub",      bus.out_instr, 32'h402081B3);
      chk("bp_addr_inc", bus.out_addr,  32'h28);
      tick();

      // reset after the LUI of a two-word LI has been taken
      req(OP_LI, 5'd5, 5'd0, 5'd0, 32'h12345678);
      tick();
      bus.req_valid = 1'b0;
      sample();
      chk("rli_lui", bus.out_instr, 32'h123452B7);
      tick();
      rst_n = 1'b0;
      #1;
      chk("rli_valid", 32'(bus.out_valid), 32'd0);
      chk("rli_addr",  bus.out_addr, 32'h0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         sample();
         chk("rli_no_addi", 32'(bus.out_valid), 32'd0);
         tick();
      end
      chk("rli_addr_end", bus.out_addr, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
